engine_scheduler: RTL and testbench
===================================

// Module: engine_scheduler
// PURPOSE
//   Sequences a bank of NUM_ENGINES pixel engines over one full frame in raster order.
//   Issues batches of consecutive pixel coordinates, waits for every active engine to finish,
//   then serialises the batch results onto a valid/ready pixel stream in ascending pixel order.
//   Sits between the frame controller (frame_start/frame_done) and the engine array/pixel sink.
// PARAMETERS
//   PIXEL_DATA_WIDTH  10      width of each x / y coordinate
//   SCREEN_WIDTH      640     pixels per line; must be >= NUM_ENGINES
//   SCREEN_HEIGHT     480     lines per frame
//   NUM_ENGINES       8       engines in the bank (>= 1)
//   RESULT_WIDTH      8       width of one engine result (e.g. iteration count)
// PORTS
//   clk          in   1                          system clock, all logic rising-edge
//   reset        in   1                          asynchronous, active-low; clears all state
//   frame_start  in   1                          pulse: begin a frame; ignored while busy=1
//   eng_start    out  NUM_ENGINES                per-engine 1-cycle start pulse
//   eng_x        out  NUM_ENGINES*PIXEL_DATA_WIDTH  engine i x at [i*PDW +: PDW]
//   eng_y        out  NUM_ENGINES*PIXEL_DATA_WIDTH  engine i y, same packing
//   eng_done     in   NUM_ENGINES                per-engine done (pulse or level)
//   eng_result   in   NUM_ENGINES*RESULT_WIDTH   engine i result, valid while its eng_done=1
//   out_valid    out  1                          stream data valid
//   out_ready    in   1                          sink can accept
//   out_data     out  RESULT_WIDTH               pixel result
//   out_x/out_y  out  PIXEL_DATA_WIDTH each      coordinates of out_data
//   out_last     out  1                          marks final pixel of frame (with out_valid)
//   busy         out  1                          high from the cycle after accepted frame_start until frame_done
//   frame_done   out  1                          1-cycle pulse when the frame's last pixel is transferred
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; base x0=y0=0; done flags, result regs, drain index cleared.
//   FSM IDLE -> ISSUE -> WAIT -> DRAIN -> (ISSUE | IDLE).
//   IDLE: frame_start=1 -> ISSUE next cycle, x0=y0=0, busy=1.
//   ISSUE (1 cycle): eng_start[i]=1 for each active engine i; clear done flags; -> WAIT.
//     Engine i active iff pixel index base+i <= W*H-1 (partial final batch allowed).
//     Coordinates: xi=x0+i, yi=y0; if xi>=W then xi-=W, yi+=1 (single subtract, no divider).
//     eng_x/eng_y registered, valid in ISSUE, held stable through WAIT and DRAIN.
//   WAIT: from cycle after ISSUE, eng_done[i]=1 on active i sets sticky flag i and captures
//     eng_result[i]; later done pulses on a flagged engine ignored; inactive engines ignored.
//     All active flags set (incl. same-cycle arrivals) -> DRAIN next cycle, idx=0.
//   DRAIN: out_valid=1, out_data=res[idx], out_x/out_y=coords of engine idx (registered).
//     Transfer on out_valid&&out_ready only; outputs hold stable while out_ready=0.
//     Transfer at last active idx: if final batch -> out_last was 1 for it, -> IDLE, frame_done
//     pulses next cycle, busy=0 same cycle; else x0/y0 advance by NUM_ENGINES with line wrap
//     (x0>=W -> x0-=W, y0+=1) -> ISSUE.
//   Throughput: one pixel per cycle in DRAIN with out_ready=1; 1 cycle ISSUE overhead per batch.
//   frame_start while busy: ignored, no effect. Reset asserted mid-frame: immediate return
//   to IDLE, outputs 0, no frame_done; next frame restarts at (0,0).
//   Widths: internal pixel counter must hold W*H (>= ceil(log2(W*H+1)) bits).
// TESTING
//   1. Reset then frame_start, engines done 3 cycles after start -> first batch eng_x=0..7,
//      eng_y=0; stream emits (0,0)..(7,0) in order with matching results.
//   2. Line wrap, W=12,H=2,N=8 -> batch 2 coords x=8..11 y=0 then x=0..3 y=1; stream stays raster.
//   3. Out-of-order done (engine 7 first, engine 0 last, two same cycle) -> DRAIN only after
//      last done; out_data order still engine 0..7.
//   4. out_ready toggled randomly -> no drop/duplicate; out_* stable while stalled; W*H pixels total.
//   5. W=10,H=1,N=4 -> final batch has 2 active engines; eng_start=4'b0011; out_last on (9,0);
//      frame_done 1 cycle later; extra frame_start during frame ignored.
//   6. reset low during WAIT -> all outputs 0 next edge; new frame_start restarts at (0,0).

Source files
------------

// File: rtl/engine_scheduler_if.sv
// Result pixel stream from the engine scheduler to the pixel sink.
// The scheduler is the master; the sink drives out_ready.
interface engine_scheduler_if #(
  parameter int PIXEL_DATA_WIDTH = 10,
  parameter int RESULT_WIDTH     = 8
);
  logic                        out_valid;
  logic                        out_ready;
  logic [RESULT_WIDTH-1:0]     out_data;
  logic [PIXEL_DATA_WIDTH-1:0] out_x;
  logic [PIXEL_DATA_WIDTH-1:0] out_y;
  logic                        out_last;

  modport master (output out_valid, out_data, out_x, out_y, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_x, out_y, out_last, output out_ready);
endinterface

// File: rtl/engine_scheduler.sv
// Raster-order batch scheduler for a bank of pixel engines: issue a batch,
// collect every active engine's result, then stream them out in pixel order.
module engine_scheduler #(
  parameter int PIXEL_DATA_WIDTH = 10,
  parameter int SCREEN_WIDTH     = 640,
  parameter int SCREEN_HEIGHT    = 480,
  parameter int NUM_ENGINES      = 8,
  parameter int RESULT_WIDTH     = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    frame_start,
  output logic [NUM_ENGINES-1:0]                  eng_start,
  output logic [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0] eng_x,
  output logic [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0] eng_y,
  input  logic [NUM_ENGINES-1:0]                  eng_done,
  input  logic [NUM_ENGINES*RESULT_WIDTH-1:0]     eng_result,
  engine_scheduler_if.master                      pix,
  output logic                                    busy,
  output logic                                    frame_done
);
  localparam int          PDW   = PIXEL_DATA_WIDTH;
  localparam int          RW    = RESULT_WIDTH;
  localparam int          W     = SCREEN_WIDTH;
  localparam int unsigned NE    = NUM_ENGINES;
  localparam int          TOTAL = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int          BW    = $clog2(TOTAL + NUM_ENGINES + 1);
  localparam int          IW    = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam int          CXW   = PDW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_e;

  state_e         state_q;
  logic [PDW-1:0] x0_q, y0_q;
  logic [BW-1:0]  base_q;
  logic           last_batch_q;
  logic [NE-1:0]  start_q, act_q, done_q;
  logic [PDW-1:0] ex_q [NE];
  logic [PDW-1:0] ey_q [NE];
  logic [RW-1:0]  res_q [NE];
  logic [IW-1:0]  idx_q;
  logic           out_valid_q, out_last_q, busy_q, frame_done_q;
  logic [RW-1:0]  out_data_q;
  logic [PDW-1:0] out_x_q, out_y_q;

  logic [CXW-1:0] adv_x, xi;
  logic [PDW-1:0] adv_y, yi;
  logic [PDW-1:0] bx_d, by_d;
  logic [BW-1:0]  bbase_d;
  logic [PDW-1:0] nx_d [NE];
  logic [PDW-1:0] ny_d [NE];
  logic [NE-1:0]  nact_d, cap_d, done_d, last_mask;
  logic           nlast_d, go_issue;
  logic [RW-1:0]  res_d [NE];
  logic [IW-1:0]  nidx_d;

  always_comb begin
    adv_x = {1'b0, x0_q} + CXW'(NE);
    adv_y = y0_q;
    if (adv_x >= CXW'(W)) begin
      adv_x = adv_x - CXW'(W);
      adv_y = y0_q + PDW'(1);
    end
    if (state_q == S_IDLE) begin
      bx_d    = '0;
      by_d    = '0;
      bbase_d = '0;
    end else begin
      bx_d    = PDW'(adv_x);
      by_d    = adv_y;
      bbase_d = base_q + BW'(NE);
    end
    nlast_d = (bbase_d + BW'(NE)) >= BW'(TOTAL);
    xi      = '0;
    yi      = '0;
    // Engine offsets never exceed one line, so a single subtract wraps them.
    for (int unsigned i = 0; i < NE; i++) begin
      xi = {1'b0, bx_d} + CXW'(i);
      yi = by_d;
      if (xi >= CXW'(W)) begin
        xi = xi - CXW'(W);
        yi = by_d + PDW'(1);
      end
      nx_d[i]   = PDW'(xi);
      ny_d[i]   = yi;
      nact_d[i] = (bbase_d + BW'(i)) < BW'(TOTAL);
    end
    cap_d  = (state_q == S_WAIT) ? (eng_done & act_q & ~done_q) : '0;
    done_d = done_q | cap_d;
    for (int unsigned i = 0; i < NE; i++)
      res_d[i] = cap_d[i] ? eng_result[i*RW +: RW] : res_q[i];
    // Active engines form a prefix, so the last one is where the mask ends.
    last_mask = act_q & ~(act_q >> 1);
    nidx_d    = idx_q + IW'(1);
    go_issue  = ((state_q == S_IDLE) && frame_start) ||
                ((state_q == S_DRAIN) && pix.out_ready && last_mask[idx_q] && !last_batch_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      x0_q         <= '0;
      y0_q         <= '0;
      base_q       <= '0;
      last_batch_q <= 1'b0;
      start_q      <= '0;
      act_q        <= '0;
      done_q       <= '0;
      idx_q        <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      for (int unsigned i = 0; i < NE; i++) begin
        ex_q[i]  <= '0;
        ey_q[i]  <= '0;
        res_q[i] <= '0;
      end
    end else begin
      start_q      <= '0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (frame_start) begin
          state_q <= S_ISSUE;
          busy_q  <= 1'b1;
        end
        S_ISSUE: begin
          done_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          done_q <= done_d;
          res_q  <= res_d;
          if ((done_d & act_q) == act_q) begin
            state_q     <= S_DRAIN;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= res_d[0];
            out_x_q     <= ex_q[0];
            out_y_q     <= ey_q[0];
            out_last_q  <= last_batch_q && last_mask[0];
          end
        end
        S_DRAIN: if (pix.out_ready) begin
          if (last_mask[idx_q]) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (last_batch_q) begin
              state_q      <= S_IDLE;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
            end
          end else begin
            idx_q      <= nidx_d;
            out_data_q <= res_q[nidx_d];
            out_x_q    <= ex_q[nidx_d];
            out_y_q    <= ey_q[nidx_d];
            out_last_q <= last_batch_q && last_mask[nidx_d];
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Shared batch load for both the first batch and each following one.
      if (go_issue) begin
        x0_q         <= bx_d;
        y0_q         <= by_d;
        base_q       <= bbase_d;
        last_batch_q <= nlast_d;
        start_q      <= nact_d;
        act_q        <= nact_d;
        ex_q         <= nx_d;
        ey_q         <= ny_d;
      end
    end
  end

  for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_flat
    assign eng_x[g*PDW +: PDW] = ex_q[g];
    assign eng_y[g*PDW +: PDW] = ey_q[g];
  end

  assign eng_start     = start_q;
  assign pix.out_valid = out_valid_q;
  assign pix.out_data  = out_data_q;
  assign pix.out_x     = out_x_q;
  assign pix.out_y     = out_y_q;
  assign pix.out_last  = out_last_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
endmodule

// File: tb/tb_engine_scheduler.sv
// Directed bench for engine_scheduler: three configurations (640x480/8, 12x2/8,
// 10x1/4) driven by delay-programmable engine models and a raster stream checker.
module tb_engine_scheduler;
  localparam int PDW = 10;
  localparam int RW  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned n_run = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] f(input logic [PDW-1:0] x, input logic [PDW-1:0] y);
    return 8'(x * 7 + y * 13 + 1);
  endfunction

  // ---------------- instance A: 640x480, 8 engines ----------------
  logic fsA, busyA, fdA;
  logic [7:0] stA, edA;
  logic [79:0] exA, eyA;
  logic [63:0] erA;
  engine_scheduler_if #(.PIXEL_DATA_WIDTH(PDW), .RESULT_WIDTH(RW)) ifA();
  engine_scheduler #(.PIXEL_DATA_WIDTH(PDW), .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480),
                     .NUM_ENGINES(8), .RESULT_WIDTH(RW)) uA (
    .clk(clk), .reset(reset), .frame_start(fsA), .eng_start(stA), .eng_x(exA), .eng_y(eyA),
    .eng_done(edA), .eng_result(erA), .pix(ifA), .busy(busyA), .frame_done(fdA));

  // ---------------- instance B: 12x2, 8 engines ----------------
  logic fsB, busyB, fdB;
  logic [7:0] stB, edB;
  logic [79:0] exB, eyB;
  logic [63:0] erB;
  engine_scheduler_if #(.PIXEL_DATA_WIDTH(PDW), .RESULT_WIDTH(RW)) ifB();
  engine_scheduler #(.PIXEL_DATA_WIDTH(PDW), .SCREEN_WIDTH(12), .SCREEN_HEIGHT(2),
                     .NUM_ENGINES(8), .RESULT_WIDTH(RW)) uB (
    .clk(clk), .reset(reset), .frame_start(fsB), .eng_start(stB), .eng_x(exB), .eng_y(eyB),
    .eng_done(edB), .eng_result(erB), .pix(ifB), .busy(busyB), .frame_done(fdB));

  // ---------------- instance C: 10x1, 4 engines ----------------
  logic fsC, busyC, fdC;
  logic [3:0] stC, edC;
  logic [39:0] exC, eyC;
  logic [31:0] erC;
  engine_scheduler_if #(.PIXEL_DATA_WIDTH(PDW), .RESULT_WIDTH(RW)) ifC();
  engine_scheduler #(.PIXEL_DATA_WIDTH(PDW), .SCREEN_WIDTH(10), .SCREEN_HEIGHT(1),
                     .NUM_ENGINES(4), .RESULT_WIDTH(RW)) uC (
    .clk(clk), .reset(reset), .frame_start(fsC), .eng_start(stC), .eng_x(exC), .eng_y(eyC),
    .eng_done(edC), .eng_result(erC), .pix(ifC), .busy(busyC), .frame_done(fdC));

  // Engine models: done pulses d cycles after the start cycle, result = f(x,y).
  int dA[8], cA[8], dB[8], cB[8], dC[4], cC[4];
  int nsA = 0, nsB = 0, nsC = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      edA[i] = 1'b0;
      if (!reset) cA[i] = 0;
      else begin
        if (cA[i] > 0) begin
          cA[i]--;
          if (cA[i] == 0) begin edA[i] = 1'b1; erA[i*8 +: 8] = f(exA[i*10 +: 10], eyA[i*10 +: 10]); end
        end
        if (stA[i]) cA[i] = dA[i];
      end
    end
    if (reset && stA != 0) nsA++;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      edB[i] = 1'b0;
      if (!reset) cB[i] = 0;
      else begin
        if (cB[i] > 0) begin
          cB[i]--;
          if (cB[i] == 0) begin edB[i] = 1'b1; erB[i*8 +: 8] = f(exB[i*10 +: 10], eyB[i*10 +: 10]); end
        end
        if (stB[i]) cB[i] = dB[i];
      end
    end
    if (reset && stB != 0) nsB++;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      edC[i] = 1'b0;
      if (!reset) cC[i] = 0;
      else begin
        if (cC[i] > 0) begin
          cC[i]--;
          if (cC[i] == 0) begin edC[i] = 1'b1; erC[i*8 +: 8] = f(exC[i*10 +: 10], eyC[i*10 +: 10]); end
        end
        if (stC[i]) cC[i] = dC[i];
      end
    end
    if (reset && stC != 0) nsC++;
  end

  // Stream checkers: expected pixels follow an independent raster counter.
  int xA = 0, yA = 0, pA = 0, fdcA = 0;
  always @(negedge clk) begin
    if (!reset) begin
      xA = 0; yA = 0; pA = 0; ifA.out_ready = 1'b0;
    end else begin
      ifA.out_ready = 1'b1;
      if (fdA) fdcA++;
      if (ifA.out_valid && ifA.out_ready) begin
        check("A out_x", 32'(ifA.out_x), xA);
        check("A out_y", 32'(ifA.out_y), yA);
        check("A out_data", 32'(ifA.out_data), 32'(f(PDW'(xA), PDW'(yA))));
        check("A out_last", 32'(ifA.out_last), 0);
        pA++; xA++;
        if (xA == 640) begin xA = 0; yA++; end
      end
    end
  end

  int xB = 0, yB = 0, pB = 0, fdcB = 0;
  logic pvB = 1'b0, prB = 1'b0;
  logic [29:0] snapB;
  always @(negedge clk) begin
    if (!reset) begin
      xB = 0; yB = 0; pB = 0; pvB = 1'b0; prB = 1'b0; ifB.out_ready = 1'b0;
    end else begin
      ifB.out_ready = 1'($urandom_range(0, 1));
      if (fdB) fdcB++;
      if (pvB && !prB)
        check("B stall hold", 32'({ifB.out_valid, ifB.out_last, ifB.out_data, ifB.out_x, ifB.out_y}),
              32'(snapB));
      if (ifB.out_valid && ifB.out_ready) begin
        check("B out_x", 32'(ifB.out_x), xB);
        check("B out_y", 32'(ifB.out_y), yB);
        check("B out_data", 32'(ifB.out_data), 32'(f(PDW'(xB), PDW'(yB))));
        check("B out_last", 32'(ifB.out_last), (pB == 23) ? 1 : 0);
        pB++; xB++;
        if (xB == 12) begin xB = 0; yB++; end
      end
      pvB   = ifB.out_valid;
      prB   = ifB.out_ready;
      snapB = {ifB.out_valid, ifB.out_last, ifB.out_data, ifB.out_x, ifB.out_y};
    end
  end

  int pC = 0, fdcC = 0, lastC = -1;
  always @(negedge clk) begin
    if (!reset) begin
      pC = 0; ifC.out_ready = 1'b0;
    end else begin
      ifC.out_ready = 1'b1;
      if (fdC) begin
        fdcC++;
        check("C frame_done cycle", cyc, lastC);
        check("C busy at frame_done", 32'(busyC), 0);
      end
      if (ifC.out_valid && ifC.out_ready) begin
        check("C out_x", 32'(ifC.out_x), pC);
        check("C out_y", 32'(ifC.out_y), 0);
        check("C out_data", 32'(ifC.out_data), 32'(f(PDW'(pC), PDW'(0))));
        check("C out_last", 32'(ifC.out_last), (pC == 9) ? 1 : 0);
        if (ifC.out_last) lastC = cyc + 1;
        pC++;
      end
    end
  end

  int bx2[8] = '{8, 9, 10, 11, 0, 1, 2, 3};
  int by2[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  int t, s0;

  initial begin
    reset = 1'b0; fsA = 1'b0; fsB = 1'b0; fsC = 1'b0;
    erA = '0; erB = '0; erC = '0;
    for (int i = 0; i < 8; i++) begin dA[i] = 3; dB[i] = (i % 3) + 1; end
    for (int i = 0; i < 4; i++) dC[i] = 2;
    repeat (3) @(negedge clk);
    #1;
    check("reset out_valid", 32'(ifA.out_valid), 0);
    check("reset busy", 32'(busyA), 0);
    check("reset eng_start", 32'(stA), 0);
    check("reset eng_xy zero", 32'(|{exA, eyA}), 0);
    check("reset out_data/last", 32'({ifA.out_data, ifA.out_last, fdA}), 0);
    reset = 1'b1;
    @(negedge clk); #1;

    // 1: first batch, all engines done after 3 cycles
    fsA = 1'b1;
    @(negedge clk); #1;
    fsA = 1'b0;
    check("T1 busy", 32'(busyA), 1);
    check("T1 eng_start", 32'(stA), 32'hFF);
    for (int i = 0; i < 8; i++) begin
      check("T1 eng_x", 32'(exA[i*10 +: 10]), i);
      check("T1 eng_y", 32'(eyA[i*10 +: 10]), 0);
    end
    // 3: out-of-order completion for the second batch (engine 7 first, 0 last, 2/3 together)
    dA = '{6, 3, 4, 4, 5, 2, 3, 1};
    t = 0;
    while (!ifA.out_valid && t < 50) begin @(negedge clk); #1; t++; end
    check("T1 issue-to-valid", t, 4);
    t = 0;
    while (stA == 0 && t < 50) begin @(negedge clk); #1; t++; end
    check("T1 drained 8", pA, 8);
    for (int i = 0; i < 8; i++) check("T3 eng_x", 32'(exA[i*10 +: 10]), 8 + i);
    t = 0;
    while (!ifA.out_valid && t < 50) begin @(negedge clk); #1; t++; end
    check("T3 issue-to-valid", t, 7);

    // 6: reset while the third batch is waiting
    t = 0;
    while (stA == 0 && t < 50) begin @(negedge clk); #1; t++; end
    check("T6 third batch x0", 32'(exA[9:0]), 16);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check("T6 rst out_valid", 32'(ifA.out_valid), 0);
    check("T6 rst busy", 32'(busyA), 0);
    check("T6 rst eng_start", 32'(stA), 0);
    check("T6 rst eng_xy", 32'(|{exA, eyA}), 0);
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    check("T6 no frame_done", fdcA, 0);
    for (int i = 0; i < 8; i++) dA[i] = 2;
    fsA = 1'b1;
    @(negedge clk); #1;
    fsA = 1'b0;
    check("T6 restart eng_start", 32'(stA), 32'hFF);
    for (int i = 0; i < 8; i++) check("T6 restart eng_x", 32'(exA[i*10 +: 10]), i);
    check("T6 restart eng_y", 32'(|eyA), 0);
    t = 0;
    while (pA < 8 && t < 50) begin @(negedge clk); #1; t++; end
    check("T6 restart drained", pA, 8);

    // 2 + 4: line wrap with random back-pressure on a 12x2 frame
    s0 = nsB;
    fsB = 1'b1;
    @(negedge clk); #1;
    fsB = 1'b0;
    t = 0;
    while (nsB < s0 + 2 && t < 300) begin @(negedge clk); #1; t++; end
    check("T2 second batch seen", nsB - s0, 2);
    check("T2 eng_start", 32'(stB), 32'hFF);
    for (int i = 0; i < 8; i++) begin
      check("T2 eng_x", 32'(exB[i*10 +: 10]), bx2[i]);
      check("T2 eng_y", 32'(eyB[i*10 +: 10]), by2[i]);
    end
    t = 0;
    while (fdcB == 0 && t < 600) begin @(negedge clk); #1; t++; end
    check("T4 pixel count", pB, 24);
    check("T4 frame_done count", fdcB, 1);
    check("T4 busy cleared", 32'(busyB), 0);
    check("T4 batch count", nsB - s0, 3);

    // 5: partial final batch on a 10x1 frame, extra frame_start ignored
    s0 = nsC;
    fsC = 1'b1;
    @(negedge clk); #1;
    fsC = 1'b0;
    check("T5 first eng_start", 32'(stC), 32'hF);
    @(negedge clk); #1;
    fsC = 1'b1;
    @(negedge clk); #1;
    fsC = 1'b0;
    t = 0;
    while (nsC < s0 + 3 && t < 200) begin @(negedge clk); #1; t++; end
    check("T5 final eng_start", 32'(stC), 32'h3);
    check("T5 final eng_x0", 32'(exC[9:0]), 8);
    check("T5 final eng_x1", 32'(exC[19:10]), 9);
    check("T5 busy in frame", 32'(busyC), 1);
    t = 0;
    while (fdcC == 0 && t < 200) begin @(negedge clk); #1; t++; end
    repeat (10) @(negedge clk);
    #1;
    check("T5 pixel count", pC, 10);
    check("T5 frame_done count", fdcC, 1);
    check("T5 no restart", nsC - s0, 3);
    check("T5 idle busy", 32'(busyC), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
